decode_stage: RTL and testbench

//  Parametrised decode stage between IF and EX of the pipelined CPU. Splits the instruction into

---
 rtl/decode_stage.sv | 159 +++++++++++++++
 tb/tb_decode_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage between IF and EX: splits the instruction, sign-extends the immediate,
// forwards operands from EX/WB, and interlocks one bubble behind a load with a dependant.
module decode_stage #(
  parameter int              DATA_W      = 16,
  parameter int              RA_W        = 3,
  parameter int              OP_W        = 4,
  parameter int              IMM_FIELD_W = 3,
  parameter logic [OP_W-1:0] LOAD_OP     = 4'hA,
  parameter bit              FWD_EN      = 1'b1,
  localparam int             INSTR_W     = OP_W + 3*RA_W + IMM_FIELD_W
) (
  input  logic               clk_dc,
  input  logic               rst_dc,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic [RA_W-1:0]    rf_sr_addr,
  output logic [RA_W-1:0]    rf_tr_addr,
  input  logic [DATA_W-1:0]  rf_sr_data,
  input  logic [DATA_W-1:0]  rf_tr_data,
  input  logic               ex_wr_en,
  input  logic [RA_W-1:0]    ex_wr_addr,
  input  logic [DATA_W-1:0]  ex_wr_data,
  input  logic               wb_wr_en,
  input  logic [RA_W-1:0]    wb_wr_addr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               dc_valid,
  output logic [OP_W-1:0]    op_code,
  output logic [RA_W-1:0]    dr_addr,
  output logic [RA_W-1:0]    sr_addr,
  output logic [RA_W-1:0]    tr_addr,
  output logic [DATA_W-1:0]  sr_data,
  output logic [DATA_W-1:0]  tr_data,
  output logic [DATA_W-1:0]  imm
);

  function automatic logic [DATA_W-1:0] sign_extend(input logic [IMM_FIELD_W-1:0] field);
    return {{(DATA_W-IMM_FIELD_W){field[IMM_FIELD_W-1]}}, field};
  endfunction

  // EX result is younger than WB, so it wins when both target the same register.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [RA_W-1:0]   addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_en,
    input logic [RA_W-1:0]   ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              wb_en,
    input logic [RA_W-1:0]   wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] result;
    if (FWD_EN && ex_en && (ex_addr == addr)) begin
      result = ex_data;
    end else if (FWD_EN && wb_en && (wb_addr == addr)) begin
      result = wb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  logic [OP_W-1:0]        w_op;
  logic [RA_W-1:0]        w_dr;
  logic [RA_W-1:0]        w_sr;
  logic [RA_W-1:0]        w_tr;
  logic [IMM_FIELD_W-1:0] w_imm_field;
  logic                   w_advance;
  logic                   w_hazard;
  logic                   w_if_ready;
  logic                   w_accept;
  logic [DATA_W-1:0]      w_sr_operand;
  logic [DATA_W-1:0]      w_tr_operand;

  logic                   r_dc_valid;
  logic [OP_W-1:0]        r_op_code;
  logic [RA_W-1:0]        r_dr_addr;
  logic [RA_W-1:0]        r_sr_addr;
  logic [RA_W-1:0]        r_tr_addr;
  logic [DATA_W-1:0]      r_sr_data;
  logic [DATA_W-1:0]      r_tr_data;
  logic [DATA_W-1:0]      r_imm;

  assign w_op        = instruction[OP_W-1:0];
  assign w_dr        = instruction[OP_W +: RA_W];
  assign w_sr        = instruction[OP_W + RA_W +: RA_W];
  assign w_tr        = instruction[OP_W + 2*RA_W +: RA_W];
  assign w_imm_field = instruction[INSTR_W-1 -: IMM_FIELD_W];

  assign rf_sr_addr  = w_sr;
  assign rf_tr_addr  = w_tr;

  // Handshake: the hazard compares the held load against the fields being offered now.
  always_comb begin
    w_advance  = !r_dc_valid || ex_ready;
    w_hazard   = 1'b0;
    if (r_dc_valid && (r_op_code == LOAD_OP) &&
        ((r_dr_addr == w_sr) || (r_dr_addr == w_tr))) begin
      w_hazard = 1'b1;
    end else begin
      w_hazard = 1'b0;
    end
    if (flush) begin
      w_if_ready = 1'b1;
    end else begin
      w_if_ready = w_advance && !w_hazard;
    end
    w_accept   = if_valid && w_if_ready && !flush;
  end

  assign if_ready = w_if_ready;

  // Operands are resolved only on the accepting cycle; a stall never re-forwards.
  always_comb begin
    w_sr_operand = select_operand(w_sr, rf_sr_data, ex_wr_en, ex_wr_addr, ex_wr_data,
                                  wb_wr_en, wb_wr_addr, wb_wr_data);
    w_tr_operand = select_operand(w_tr, rf_tr_data, ex_wr_en, ex_wr_addr, ex_wr_data,
                                  wb_wr_en, wb_wr_addr, wb_wr_data);
  end

  // Output register bank: reset > flush > accept > bubble > stall (hold).
  always_ff @(posedge clk_dc) begin
    if (rst_dc) begin
      r_dc_valid <= 1'b0;
      r_op_code  <= '0;
      r_dr_addr  <= '0;
      r_sr_addr  <= '0;
      r_tr_addr  <= '0;
      r_sr_data  <= '0;
      r_tr_data  <= '0;
      r_imm      <= '0;
    end else if (flush) begin
      r_dc_valid <= 1'b0;
    end else if (w_accept) begin
      r_dc_valid <= 1'b1;
      r_op_code  <= w_op;
      r_dr_addr  <= w_dr;
      r_sr_addr  <= w_sr;
      r_tr_addr  <= w_tr;
      r_sr_data  <= w_sr_operand;
      r_tr_data  <= w_tr_operand;
      r_imm      <= sign_extend(w_imm_field);
    end else if (w_advance) begin
      r_dc_valid <= 1'b0;
    end
  end

  assign dc_valid = r_dc_valid;
  assign op_code  = r_op_code;
  assign dr_addr  = r_dr_addr;
  assign sr_addr  = r_sr_addr;
  assign tr_addr  = r_tr_addr;
  assign sr_data  = r_sr_data;
  assign tr_data  = r_tr_data;
  assign imm      = r_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, field split, forwarding priority, stall,
// load-use interlock and flush, with hand-computed expectations.
module tb_decode_stage;

  logic        clk_dc = 1'b0;
  logic        rst_dc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] instruction;
  logic [2:0]  rf_sr_addr;
  logic [2:0]  rf_tr_addr;
  logic [15:0] rf_sr_data;
  logic [15:0] rf_tr_data;
  logic        ex_wr_en;
  logic [2:0]  ex_wr_addr;
  logic [15:0] ex_wr_data;
  logic        wb_wr_en;
  logic [2:0]  wb_wr_addr;
  logic [15:0] wb_wr_data;
  logic        ex_ready;
  logic        flush;
  logic        dc_valid;
  logic [3:0]  op_code;
  logic [2:0]  dr_addr;
  logic [2:0]  sr_addr;
  logic [2:0]  tr_addr;
  logic [15:0] sr_data;
  logic [15:0] tr_data;
  logic [15:0] imm;

  int vectors     = 0;
  int miscompares = 0;

  decode_stage dut (
    .clk_dc(clk_dc), .rst_dc(rst_dc), .if_valid(if_valid), .if_ready(if_ready),
    .instruction(instruction), .rf_sr_addr(rf_sr_addr), .rf_tr_addr(rf_tr_addr),
    .rf_sr_data(rf_sr_data), .rf_tr_data(rf_tr_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_ready(ex_ready), .flush(flush), .dc_valid(dc_valid), .op_code(op_code),
    .dr_addr(dr_addr), .sr_addr(sr_addr), .tr_addr(tr_addr),
    .sr_data(sr_data), .tr_data(tr_data), .imm(imm)
  );

  always #5 clk_dc = ~clk_dc;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] dr,
                                     input logic [2:0] sr, input logic [2:0] tr,
                                     input logic [2:0] im);
    return {im, tr, sr, dr, op};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_dc);
    #1;
  endtask

  initial begin
    rst_dc = 1'b1; if_valid = 1'b1; instruction = 16'hA4B3;
    rf_sr_data = 16'h1111; rf_tr_data = 16'h2222;
    ex_wr_en = 1'b0; ex_wr_addr = 3'd0; ex_wr_data = 16'h0000;
    wb_wr_en = 1'b0; wb_wr_addr = 3'd0; wb_wr_data = 16'h0000;
    ex_ready = 1'b1; flush = 1'b0;

    // reset held two cycles with a valid instruction offered
    step(); step();
    chk("rst_valid", 16'(dc_valid), 16'h0);
    chk("rst_op", 16'(op_code), 16'h0);
    chk("rst_dr", 16'(dr_addr), 16'h0);
    chk("rst_sr_data", sr_data, 16'h0000);
    chk("rst_tr_data", tr_data, 16'h0000);
    chk("rst_imm", imm, 16'h0000);

    rst_dc = 1'b0; #1;
    chk("rel_if_ready", 16'(if_ready), 16'h1);
    chk("rf_sr_addr", 16'(rf_sr_addr), 16'h1);
    chk("rf_tr_addr", 16'(rf_tr_addr), 16'h1);
    step();
    chk("dec_valid", 16'(dc_valid), 16'h1);
    chk("dec_op", 16'(op_code), 16'h3);
    chk("dec_dr", 16'(dr_addr), 16'h3);
    chk("dec_sr", 16'(sr_addr), 16'h1);
    chk("dec_tr", 16'(tr_addr), 16'h1);
    chk("dec_imm", imm, 16'hFFFD);
    chk("dec_sr_data", sr_data, 16'h1111);
    chk("dec_tr_data", tr_data, 16'h2222);

    // EX and WB both match sr: EX wins
    instruction = mk(4'h1, 3'd5, 3'd4, 3'd6, 3'd0);
    rf_sr_data = 16'h1234; rf_tr_data = 16'h5678;
    ex_wr_en = 1'b1; ex_wr_addr = 3'd4; ex_wr_data = 16'h00EE;
    wb_wr_en = 1'b1; wb_wr_addr = 3'd4; wb_wr_data = 16'h00BB;
    step();
    chk("fwd_ex_sr", sr_data, 16'h00EE);
    chk("fwd_ex_tr_rf", tr_data, 16'h5678);
    chk("fwd_ex_imm", imm, 16'h0000);

    // WB only, both sources match
    instruction = mk(4'h2, 3'd1, 3'd4, 3'd4, 3'd3);
    ex_wr_en = 1'b0;
    step();
    chk("fwd_wb_sr", sr_data, 16'h00BB);
    chk("fwd_wb_tr", tr_data, 16'h00BB);
    chk("fwd_wb_imm", imm, 16'h0003);

    // register 0 forwards like any other; EX on tr, WB on sr
    instruction = mk(4'h0, 3'd0, 3'd0, 3'd7, 3'd0);
    ex_wr_en = 1'b1; ex_wr_addr = 3'd7; ex_wr_data = 16'h0077;
    wb_wr_en = 1'b1; wb_wr_addr = 3'd0; wb_wr_data = 16'h0055;
    step();
    chk("fwd_r0_sr", sr_data, 16'h0055);
    chk("fwd_ex_tr", tr_data, 16'h0077);
    chk("fwd_r0_op", 16'(op_code), 16'h0);

    // stall three cycles with a new instruction waiting
    ex_wr_en = 1'b0; wb_wr_en = 1'b0;
    ex_ready = 1'b0;
    instruction = mk(4'h5, 3'd2, 3'd3, 3'd3, 3'd4);
    rf_sr_data = 16'hAAAA; rf_tr_data = 16'hBBBB;
    #1;
    chk("stall_if_ready", 16'(if_ready), 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 16'(dc_valid), 16'h1);
      chk("stall_op", 16'(op_code), 16'h0);
      chk("stall_sr_data", sr_data, 16'h0055);
    end
    ex_ready = 1'b1; #1;
    chk("unstall_if_ready", 16'(if_ready), 16'h1);
    step();
    chk("unstall_op", 16'(op_code), 16'h5);
    chk("unstall_imm", imm, 16'hFFFC);
    chk("unstall_sr_data", sr_data, 16'hAAAA);

    // load r2, then dependant reading r2
    instruction = mk(4'hA, 3'd2, 3'd1, 3'd1, 3'd0);
    rf_sr_data = 16'h1000; rf_tr_data = 16'h1000;
    step();
    chk("load_op", 16'(op_code), 16'hA);
    chk("load_dr", 16'(dr_addr), 16'h2);
    instruction = mk(4'h3, 3'd4, 3'd2, 3'd5, 3'd1);
    rf_sr_data = 16'hDEAD; rf_tr_data = 16'h0505;
    #1;
    chk("hazard_if_ready", 16'(if_ready), 16'h0);
    step();
    chk("bubble_valid", 16'(dc_valid), 16'h0);
    chk("bubble_if_ready", 16'(if_ready), 16'h1);
    wb_wr_en = 1'b1; wb_wr_addr = 3'd2; wb_wr_data = 16'hBEEF;
    step();
    chk("dep_valid", 16'(dc_valid), 16'h1);
    chk("dep_op", 16'(op_code), 16'h3);
    chk("dep_sr_data", sr_data, 16'hBEEF);
    chk("dep_tr_data", tr_data, 16'h0505);
    chk("dep_imm", imm, 16'h0001);

    // load r6: independent instruction may follow, tr dependency may not; flush overrides
    wb_wr_en = 1'b0;
    instruction = mk(4'hA, 3'd6, 3'd0, 3'd0, 3'd0);
    step();
    instruction = mk(4'h1, 3'd1, 3'd0, 3'd0, 3'd0); #1;
    chk("nohaz_if_ready", 16'(if_ready), 16'h1);
    instruction = mk(4'h1, 3'd1, 3'd0, 3'd6, 3'd0); #1;
    chk("tr_haz_if_ready", 16'(if_ready), 16'h0);
    flush = 1'b1; #1;
    chk("flush_haz_if_ready", 16'(if_ready), 16'h1);
    step();
    chk("flush_haz_valid", 16'(dc_valid), 16'h0);
    flush = 1'b0;

    // flush during stall drops the offered instruction
    instruction = mk(4'h7, 3'd3, 3'd1, 3'd2, 3'd2);
    rf_sr_data = 16'h1111; rf_tr_data = 16'h2222;
    step();
    chk("pre_flush_op", 16'(op_code), 16'h7);
    ex_ready = 1'b0; flush = 1'b1;
    instruction = mk(4'h9, 3'd1, 3'd1, 3'd1, 3'd0);
    #1;
    chk("flush_stall_if_ready", 16'(if_ready), 16'h1);
    step();
    chk("flush_stall_valid", 16'(dc_valid), 16'h0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    step();
    chk("dropped_valid", 16'(dc_valid), 16'h0);
    if_valid = 1'b1;
    step();
    chk("post_flush_valid", 16'(dc_valid), 16'h1);
    chk("post_flush_op", 16'(op_code), 16'h9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
